fetch_unit: RTL and testbench

- Parametrised successor to the single-PC instruction fetch stage.
- Holds the PC and issues in-order requests to a variable-latency instruction memory over a valid/ready handshake.
- Buffers returned instructions, each tagged with its PC, in a QUEUE_DEPTH-entry queue.
- Presents the queue head to decode with valid/ready backpressure. Absolute-target redirects flush the queue and squash in-flight responses.

---
 rtl/fetch_unit.sv | 117 +++++++++++
 tb/tb_fetch_unit.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, credit-limited in-order requests to imem, tagged instruction queue to decode.
// Define FETCH_PERF_CNT_EN to add the perf_fetched / perf_squashed / perf_stall_cycles counters.
module fetch_unit #(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_PC    = 32'h0000_0000,
  parameter int              QUEUE_DEPTH = 4,
  parameter int              PC_STEP     = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_resp_valid,
  input  logic [XLEN-1:0] imem_resp_data,
  output logic            if_valid,
  output logic [XLEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc,
  input  logic            id_ready
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_squashed,
  output logic [31:0]     perf_stall_cycles
`endif
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // valid never depends on ready, and ready may depend on anything.
  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(QUEUE_DEPTH);
  localparam logic [XLEN-1:0] STEP_C = XLEN'(PC_STEP);

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] resp_pc;
  logic [CW-1:0]   count;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   squash;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [XLEN-1:0] q_instr [QUEUE_DEPTH];
  logic [XLEN-1:0] q_pc    [QUEUE_DEPTH];

  logic [CW:0] credit_used;
  logic        req_fire;
  logic        resp_drop;
  logic        enq;
  logic        deq;

  // Squashed responses still occupy credit, so an accepted response always finds a free slot.
  assign credit_used    = {1'b0, count} + {1'b0, outstanding} + {1'b0, squash};
  assign imem_req_valid = !reset && !redirect_valid && (credit_used < DEPTH_C);
  assign imem_req_addr  = pc;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign resp_drop      = imem_resp_valid && (squash != '0);
  assign enq            = imem_resp_valid && (squash == '0);
  assign if_valid       = (count != '0);
  assign if_instr       = q_instr[rd_ptr];
  assign if_pc          = q_pc[rd_ptr];
  assign deq            = if_valid && id_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      pc          <= RESET_PC;
      resp_pc     <= RESET_PC;
      count       <= '0;
      outstanding <= '0;
      squash      <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else if (redirect_valid) begin
      // Every in-flight response, bar one landing right now, is now stale.
      pc          <= redirect_target;
      resp_pc     <= redirect_target;
      count       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      squash      <= squash + outstanding - CW'(imem_resp_valid);
      outstanding <= '0;
    end else begin
      if (req_fire) pc <= pc + STEP_C;
      if (resp_drop) squash <= squash - CW'(1);
      if (enq) begin
        wr_ptr  <= wr_ptr + PW'(1);
        resp_pc <= resp_pc + STEP_C;
      end
      if (deq) rd_ptr <= rd_ptr + PW'(1);
      outstanding <= outstanding + CW'(req_fire) - CW'(enq);
      count       <= count + CW'(enq) - CW'(deq);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && !redirect_valid && enq) begin
      q_instr[wr_ptr] <= imem_resp_data;
      q_pc[wr_ptr]    <= resp_pc;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      perf_fetched      <= '0;
      perf_squashed     <= '0;
      perf_stall_cycles <= '0;
    end else begin
      if (!redirect_valid && enq) perf_fetched <= perf_fetched + 32'd1;
      if (redirect_valid ? imem_resp_valid : resp_drop) perf_squashed <= perf_squashed + 32'd1;
      if (!if_valid) perf_stall_cycles <= perf_stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a variable-latency in-order memory model.
module tb_fetch_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data  = '0;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        id_ready;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_squashed, perf_stall_cycles;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int unsigned mem_lat = 1;
  int unsigned cyc = 0;
  logic [31:0] mq_addr[$];
  int unsigned mq_due[$];

  fetch_unit dut (
    .clock(clock), .reset(reset),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready), .imem_resp_valid(imem_resp_valid),
    .imem_resp_data(imem_resp_data), .if_valid(if_valid),
    .if_instr(if_instr), .if_pc(if_pc), .id_ready(id_ready)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetched(perf_fetched), .perf_squashed(perf_squashed),
    .perf_stall_cycles(perf_stall_cycles)
`endif
  );

  // ---------------- clock ----------------
  always #5 clock = ~clock;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  // Memory model: in order, response mem_lat edges after acceptance, drops everything on reset.
  always @(posedge clock) begin
    if (reset) begin
      mq_addr.delete();
      mq_due.delete();
      imem_resp_valid <= 1'b0;
    end else begin
      if (imem_resp_valid && mq_addr.size() != 0) begin
        void'(mq_addr.pop_front());
        void'(mq_due.pop_front());
      end
      if (imem_req_valid && imem_req_ready) begin
        mq_addr.push_back(imem_req_addr);
        mq_due.push_back(cyc + mem_lat);
      end
      if (mq_addr.size() != 0 && mq_due[0] <= cyc + 1) begin
        imem_resp_valid <= 1'b1;
        imem_resp_data  <= instr_of(mq_addr[0]);
      end else begin
        imem_resp_valid <= 1'b0;
        imem_resp_data  <= '0;
      end
    end
    cyc = cyc + 1;
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset(input int unsigned lat, input logic rdy);
    @(negedge clock);
    reset = 1'b1; redirect_valid = 1'b0; redirect_target = '0;
    imem_req_ready = 1'b1; id_ready = rdy; mem_lat = lat;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
  endtask

  // Captures the next decode handshake (checked at the current negedge first), bounded.
  task automatic wait_hs(output logic [31:0] pc, output logic [31:0] ins, output logic ok);
    ok = 1'b0; pc = '0; ins = '0;
    for (int i = 0; i < 64 && !ok; i++) begin
      if (if_valid && id_ready) begin
        pc = if_pc; ins = if_instr; ok = 1'b1;
      end
      @(negedge clock);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    @(negedge clock);
    reset = 1'b1; redirect_valid = 1'b0; redirect_target = '0;
    imem_req_ready = 1'b1; id_ready = 1'b1; mem_lat = 1;
    @(negedge clock);
    @(negedge clock);
    n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL reset_if_valid: got %b want 0", if_valid); end
    n_checks++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_req_valid: got %b want 0", imem_req_valid); end
    reset = 1'b0;
    #1;
    n_checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
      n_fail++; $display("FAIL first_req: got v=%b a=%h want v=1 a=00000000", imem_req_valid, imem_req_addr); end
    @(negedge clock);
    n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL latency_d1: got %b want 0", if_valid); end
    @(negedge clock);
    n_checks++; if (if_valid !== 1'b1 || if_pc !== 32'h0) begin
      n_fail++; $display("FAIL latency_d2: got v=%b pc=%h want v=1 pc=00000000", if_valid, if_pc); end
  endtask

  task automatic test_stream;
    logic [31:0] pc, ins, exp;
    logic ok;
    do_reset(1, 1'b1);
    for (int k = 0; k < 4; k++) begin
      wait_hs(pc, ins, ok);
      exp = 32'(k * 4);
      n_checks++; if (!ok || pc !== exp || ins !== instr_of(exp)) begin
        n_fail++; $display("FAIL stream_%0d: got ok=%b pc=%h ins=%h want pc=%h ins=%h", k, ok, pc, ins, exp, instr_of(exp)); end
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] pc, ins, exp;
    logic ok;
    int acc;
    do_reset(1, 1'b0);
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      if (imem_req_valid && imem_req_ready) acc++;
      @(negedge clock);
    end
    n_checks++; if (acc != 4) begin n_fail++; $display("FAIL bp_accepted: got %0d want 4", acc); end
    n_checks++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL bp_req_stall: got %b want 0", imem_req_valid); end
    n_checks++; if (if_valid !== 1'b1 || if_pc !== 32'h0) begin
      n_fail++; $display("FAIL bp_head: got v=%b pc=%h want v=1 pc=00000000", if_valid, if_pc); end
    id_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      wait_hs(pc, ins, ok);
      exp = 32'(k * 4);
      n_checks++; if (!ok || pc !== exp || ins !== instr_of(exp)) begin
        n_fail++; $display("FAIL bp_drain_%0d: got ok=%b pc=%h ins=%h want pc=%h", k, ok, pc, ins, exp); end
    end
  endtask

  task automatic test_redirect_squash;
    logic [31:0] pc, ins;
    logic ok;
    do_reset(3, 1'b1);
    @(negedge clock);
    @(negedge clock);
    n_checks++; if (imem_req_addr !== 32'h8 || if_valid !== 1'b0) begin
      n_fail++; $display("FAIL sq_pre: got a=%h v=%b want a=00000008 v=0", imem_req_addr, if_valid); end
    imem_req_ready = 1'b0; redirect_valid = 1'b1; redirect_target = 32'h100;
    @(negedge clock);
    redirect_valid = 1'b0; imem_req_ready = 1'b1;
    #1;
    n_checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin
      n_fail++; $display("FAIL sq_req: got v=%b a=%h want v=1 a=00000100", imem_req_valid, imem_req_addr); end
    wait_hs(pc, ins, ok);
    n_checks++; if (!ok || pc !== 32'h100 || ins !== instr_of(32'h100)) begin
      n_fail++; $display("FAIL sq_first: got ok=%b pc=%h ins=%h want pc=00000100 ins=%h", ok, pc, ins, instr_of(32'h100)); end
    wait_hs(pc, ins, ok);
    n_checks++; if (!ok || pc !== 32'h104 || ins !== instr_of(32'h104)) begin
      n_fail++; $display("FAIL sq_second: got ok=%b pc=%h ins=%h want pc=00000104", ok, pc, ins); end
  endtask

  task automatic test_redirect_collision;
    logic [31:0] pc, ins;
    logic ok;
    do_reset(1, 1'b1);
    @(negedge clock);
    @(negedge clock);
    n_checks++; if (if_valid !== 1'b1 || imem_resp_valid !== 1'b1) begin
      n_fail++; $display("FAIL col_pre: got if_v=%b resp_v=%b want 1 1", if_valid, imem_resp_valid); end
    redirect_valid = 1'b1; redirect_target = 32'h200;
    @(negedge clock);
    redirect_valid = 1'b0;
    #1;
    n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL col_flush: got %b want 0", if_valid); end
    n_checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h200) begin
      n_fail++; $display("FAIL col_req: got v=%b a=%h want v=1 a=00000200", imem_req_valid, imem_req_addr); end
    wait_hs(pc, ins, ok);
    n_checks++; if (!ok || pc !== 32'h200 || ins !== instr_of(32'h200)) begin
      n_fail++; $display("FAIL col_first: got ok=%b pc=%h ins=%h want pc=00000200", ok, pc, ins); end
    wait_hs(pc, ins, ok);
    n_checks++; if (!ok || pc !== 32'h204 || ins !== instr_of(32'h204)) begin
      n_fail++; $display("FAIL col_second: got ok=%b pc=%h ins=%h want pc=00000204", ok, pc, ins); end
  endtask

  task automatic test_pc_wrap;
    logic [31:0] pc, ins;
    logic ok;
    @(negedge clock);
    redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFC;
    @(negedge clock);
    redirect_valid = 1'b0;
    wait_hs(pc, ins, ok);
    n_checks++; if (!ok || pc !== 32'hFFFF_FFFC || ins !== instr_of(32'hFFFF_FFFC)) begin
      n_fail++; $display("FAIL wrap_top: got ok=%b pc=%h ins=%h want pc=fffffffc", ok, pc, ins); end
    wait_hs(pc, ins, ok);
    n_checks++; if (!ok || pc !== 32'h0 || ins !== instr_of(32'h0)) begin
      n_fail++; $display("FAIL wrap_zero: got ok=%b pc=%h ins=%h want pc=00000000", ok, pc, ins); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] pc, ins;
    logic ok;
    do_reset(3, 1'b0);
    for (int i = 0; i < 5; i++) @(negedge clock);
    n_checks++; if (if_valid !== 1'b1 || imem_req_valid !== 1'b0) begin
      n_fail++; $display("FAIL rm_pre: got if_v=%b req_v=%b want 1 0", if_valid, imem_req_valid); end
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    #1;
    n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL rm_if_valid: got %b want 0", if_valid); end
    n_checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
      n_fail++; $display("FAIL rm_req: got v=%b a=%h want v=1 a=00000000", imem_req_valid, imem_req_addr); end
    id_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      wait_hs(pc, ins, ok);
      n_checks++; if (!ok || pc !== 32'(k * 4) || ins !== instr_of(32'(k * 4))) begin
        n_fail++; $display("FAIL rm_refill_%0d: got ok=%b pc=%h ins=%h want pc=%h", k, ok, pc, ins, 32'(k * 4)); end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset = 1'b1; redirect_valid = 1'b0; redirect_target = '0;
    imem_req_ready = 1'b1; id_ready = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_squash();
    test_redirect_collision();
    test_pc_wrap();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
